// File: rtl/md_unit.sv
// md_unit: iterative RV32M mul/div unit; in_valid/in_ready take funct3, op_a, op_b and rd_in; out_valid/out_ready return result and rd_out; reg_write drives RegWrite; kill aborts.
module md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  state_e      state_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [4:0]  cnt_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [31:0] res_q;
  logic [4:0]  rd_q;
  logic        sga, sgb, sa, sb, is_div, ovf, spec, ge;
  logic [31:0] ua, ub, spec_res, dv, rnew, res_d;
  logic [32:0] msum, rsh;
  logic [63:0] acc_d, pm;
  always_comb begin
    sga      = funct3[2] ? ~funct3[0] : funct3[1] ^ funct3[0];
    sgb      = funct3[2] ? ~funct3[0] : funct3[1:0] == 2'b01;
    sa       = sga & op_a[31];
    sb       = sgb & op_b[31];
    ua       = sa ? -op_a : op_a;
    ub       = sb ? -op_b : op_b;
    is_div   = funct3[2];
    ovf      = is_div & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    spec     = is_div & ((op_b == '0) | ovf);
    spec_res = (op_b == '0) ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : 32'h8000_0000);
    msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rsh      = {acc_q[63:32], acc_q[31]};
    ge       = rsh >= {1'b0, opnd_q};
    rnew     = ge ? rsh[31:0] - opnd_q : rsh[31:0];
    acc_d    = op_q[2] ? {rnew, acc_q[30:0], ge} : {msum, acc_q[31:1]};
    pm       = neg_q ? -acc_q : acc_q;
    dv       = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    res_d    = op_q[2] ? (neg_q ? -dv : dv) : (op_q[1:0] == 2'b00 ? pm[31:0] : pm[63:32]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q    <= funct3;
          rd_q    <= rd_in;
          neg_q   <= (funct3[2] & funct3[1]) ? sa : sa ^ sb;
          cnt_q   <= '0;
          acc_q   <= {32'b0, is_div ? ua : ub};
          opnd_q  <= is_div ? ub : ua;
          res_q   <= spec_res;
          state_q <= spec ? DONE : CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          res_q   <= res_d;
          state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign rd_out    = rd_q;
  assign reg_write = out_valid && (rd_q != '0);
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit with directed corner cases and randomized ops against a reference model.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset, in_valid, kill, out_ready, in_ready, out_valid, reg_write;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;
  int          tests = 0, fails = 0;
  typedef struct {logic [31:0] res; logic [4:0] rd;} exp_t;
  exp_t sb_q[$];
  always #5 clk = ~clk;
  md_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .rd_out(rd_out), .reg_write(reg_write)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin p = sa / ((b == 0) ? 1 : sb); return (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = sa % ((b == 0) ? 1 : sb); return (b == 0) ? a : p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got result %h with nothing expected", result);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
          chk("reg_write", {31'b0, reg_write}, {31'b0, e.rd != 0});
        end
      end
    end
  end
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input logic [31:0] exp);
    int e;
    bit sp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    sb_q.push_back('{exp, rd});
    issue(f, a, b, rd);
    #1;
    for (e = 0; e < 60 && !out_valid; e++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom;
      #1;
    end
    chk("valid_edge", e, sp ? 0 : 33);
    if (!out_valid) begin
      void'(sb_q.pop_back());
      @(negedge clk); kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      return;
    end
    repeat (hold) begin
      chk("hold_result", result, exp);
      chk("hold_rd", {27'b0, rd_out}, {27'b0, rd});
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_reg_write", {31'b0, reg_write}, {31'b0, rd != 0});
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("retire_valid", {31'b0, out_valid}, 32'd0);
    chk("retire_ready", {31'b0, in_ready}, 32'd1);
  endtask
  task automatic reset_check(input string n);
    chk({n, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({n, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({n, "_reg_write"}, {31'b0, reg_write}, 32'd0);
    chk({n, "_result"}, result, 32'd0);
    chk({n, "_rd_out"}, {27'b0, rd_out}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int seen;
    logic [2:0] f;
    logic [31:0] a, b;
    reset = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #1;
    reset_check("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, 32'hFFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 32'hFFFF_FFFE);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd7, 32'd2, 5'd9, 0, 32'd3);
    run_op(3'd7, 32'd7, 32'd2, 5'd10, 0, 32'd1);
    run_op(3'd5, 32'd5, 32'd0, 5'd11, 0, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, 5'd12, 0, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 32'd0);
    run_op(3'd0, 32'd1234, 32'd5678, 5'd15, 10, 32'd7006652);
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 10, 32'd12);
    // kill while in CALC with count 10: the op must vanish
    issue(3'd0, 32'd9, 32'd9, 5'd1);
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    #1;
    chk("kill_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin @(negedge clk); #1; seen += int'(out_valid); end
    chk("kill_no_output", seen, 0);
    // kill beats in_valid in IDLE
    @(negedge clk); funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd2; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk); in_valid = 1'b0; kill = 1'b0;
    #1;
    chk("kill_prio_valid", {31'b0, out_valid}, 32'd0);
    chk("kill_prio_ready", {31'b0, in_ready}, 32'd1);
    // asynchronous reset in the middle of CALC
    issue(3'd4, 32'd100, 32'd7, 5'd17);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    reset_check("midreset");
    @(negedge clk); reset = 1'b1;
    run_op(3'd4, 32'd100, 32'd7, 5'd17, 0, 32'd14);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, 5'($urandom), $urandom_range(0, 3), ref_md(f, a, b));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
